// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: funct codes, FSM states and
// small decode helpers.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'd32;
  localparam logic [5:0] ALU_SUB   = 6'd34;
  localparam logic [5:0] ALU_AND   = 6'd36;
  localparam logic [5:0] ALU_OR    = 6'd37;
  localparam logic [5:0] ALU_SLT   = 6'd42;
  localparam logic [5:0] ALU_MULTU = 6'd25;
  localparam logic [5:0] ALU_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == ALU_MULTU) || (funct == ALU_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative engine for unsigned shift-add multiply and restoring divide,
// one result bit per clock.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             div_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic             div_ge_s;
  logic [WIDTH-1:0] div_diff_s;
  logic [WIDTH-1:0] hi_next_s;
  logic [WIDTH-1:0] lo_next_s;

  // One iteration step: m_r is the multiplicand or the divisor, lo_r holds
  // multiplier bits or dividend bits shifting out as result bits shift in.
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, m_r});
    // When the trial subtraction succeeds the true difference is below m_r.
    div_diff_s  = div_shift_s[WIDTH-1:0] - m_r;
    if (div_r) begin
      if (div_ge_s) begin
        hi_next_s = div_diff_s;
        lo_next_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_next_s = div_shift_s[WIDTH-1:0];
        lo_next_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next_s = mul_sum_s[WIDTH:1];
      lo_next_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Operand load on start, then WIDTH iterations while the counter runs down.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
      div_r  <= 1'b0;
      m_r    <= {WIDTH{1'b0}};
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
    end else if (start) begin
      cnt_r  <= CNT_W'(WIDTH);
      busy_r <= 1'b1;
      div_r  <= is_div;
      m_r    <= is_div ? b : a;
      lo_r   <= is_div ? a : b;
      hi_r   <= {WIDTH{1'b0}};
    end else if (busy_r) begin
      cnt_r  <= cnt_r - CNT_W'(1);
      busy_r <= (cnt_r != CNT_W'(1));
      hi_r   <= hi_next_s;
      lo_r   <= lo_next_s;
    end
  end

  // The final iteration's values are handed out on the edge the counter hits 0.
  assign busy = busy_r;
  assign done = busy_r && (cnt_r == CNT_W'(1));
  assign hi   = hi_next_s;
  assign lo   = lo_next_s;

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with single-cycle logic ops and iterative multu/divu,
// behind a valid/ready handshake on both sides.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  state_t           state_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             carry_r;
  logic             err_r;

  logic             accept_s;
  logic             md_start_s;
  logic             md_busy_s;
  logic             md_done_s;
  logic [WIDTH-1:0] md_hi_s;
  logic [WIDTH-1:0] md_lo_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic             slt_s;
  logic [WIDTH-1:0] sc_result_s;
  logic             sc_carry_s;
  logic             sc_err_s;

  assign in_ready   = (state_r == ST_IDLE) && !rst;
  assign accept_s   = in_valid && in_ready;
  assign md_start_s = accept_s && is_muldiv(ctl);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start_s),
    .is_div (ctl == ALU_DIVU),
    .a      (a),
    .b      (b),
    .busy   (md_busy_s),
    .done   (md_done_s),
    .hi     (md_hi_s),
    .lo     (md_lo_s)
  );

  // Single-cycle datapath, evaluated on the operands present at accept.
  always_comb begin
    add_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sub_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // Overflow-corrected sign of a-b, so wrapped differences compare right.
    slt_s = sub_s[WIDTH-1] ^ ((a[WIDTH-1] ^ b[WIDTH-1]) & (sub_s[WIDTH-1] ^ a[WIDTH-1]));
    sc_result_s = {WIDTH{1'b0}};
    sc_carry_s  = 1'b0;
    sc_err_s    = 1'b0;
    case (ctl)
      ALU_ADD: begin
        sc_result_s = add_s[WIDTH-1:0];
        sc_carry_s  = add_s[WIDTH];
      end
      ALU_SUB: begin
        sc_result_s = sub_s[WIDTH-1:0];
        sc_carry_s  = sub_s[WIDTH];
      end
      ALU_AND:   sc_result_s = a & b;
      ALU_OR:    sc_result_s = a | b;
      ALU_SLT:   sc_result_s = {{(WIDTH-1){1'b0}}, slt_s};
      ALU_MULTU: sc_err_s    = 1'b0;
      ALU_DIVU:  sc_err_s    = 1'b0;
      default:   sc_err_s    = 1'b1;
    endcase
  end

  // Control FSM with all result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      hi_r        <= {WIDTH{1'b0}};
      lo_r        <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (ctl == ALU_MULTU) begin
              state_r <= ST_MUL;
            end else if (ctl == ALU_DIVU) begin
              state_r <= ST_DIV;
            end else begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              result_r    <= sc_result_s;
              carry_r     <= sc_carry_s;
              err_r       <= sc_err_s;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_done_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            result_r    <= md_lo_s;
            hi_r        <= md_hi_s;
            lo_r        <= md_lo_s;
            carry_r     <= 1'b0;
            err_r       <= 1'b0;
          end else if (!md_busy_s) begin
            // Engine lost its operation: recover to IDLE rather than hang.
            state_r <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign hi        = hi_r;
  assign lo        = lo_r;
  assign carry     = carry_r;
  assign err       = err_r;
  assign zero      = (result_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed scenarios plus randomized
// operations against an arithmetic reference model.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic [5:0]   ctl = 6'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, carry, zero, err;
  logic [W-1:0] result, hi, lo;

  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         carry;
    logic         err;
    logic [7:0]   lat;
  } exp_t;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ctl(ctl),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .hi(hi), .lo(lo), .carry(carry), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [5:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic [W-1:0] ph, input logic [W-1:0] pl);
    exp_t e;
    logic [W:0] s;
    logic [2*W-1:0] p;
    e.res = '0; e.hi = ph; e.lo = pl; e.carry = 1'b0; e.err = 1'b0; e.lat = 8'd1;
    case (c)
      ALU_ADD: begin s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci}; e.res = s[W-1:0]; e.carry = s[W]; end
      ALU_SUB: begin e.res = x - y; e.carry = (x >= y); end
      ALU_AND: e.res = x & y;
      ALU_OR:  e.res = x | y;
      ALU_SLT: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      ALU_MULTU: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; e.res = e.lo; e.lat = 8'(W + 1);
      end
      ALU_DIVU: begin
        if (y == '0) begin e.lo = '1; e.hi = x; end
        else begin e.lo = x / y; e.hi = x % y; end
        e.res = e.lo; e.lat = 8'(W + 1);
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Presents one request; caller is one time unit past a rising edge in IDLE.
  task automatic issue(input logic [5:0] c, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    ctl = c; a = x; b = y; cin = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
    n_chk++; if ({result, hi, lo} !== {3*W{1'b0}}) $display("FAIL reset_data got=%h/%h/%h want=0", result, hi, lo); else n_pass++;
    n_chk++; if ({carry, zero, err} !== 3'b010) $display("FAIL reset_flags got=%b want=010", {carry, zero, err}); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during got=%b want=0", in_ready); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after got=%b want=1", in_ready); else n_pass++;
  endtask

  task automatic test_add_carry();
    int cyc;
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0);
    wait_valid(cyc);
    n_chk++; if (cyc !== 1) $display("FAIL add_latency got=%0d want=1", cyc); else n_pass++;
    n_chk++; if (result !== 32'h0) $display("FAIL add_result got=%h want=0", result); else n_pass++;
    n_chk++; if ({carry, zero, err} !== 3'b110) $display("FAIL add_flags got=%b want=110", {carry, zero, err}); else n_pass++;
    retire();
  endtask

  task automatic test_slt();
    int cyc;
    issue(ALU_SLT, 32'h8000_0000, 32'h1, 1'b0);
    wait_valid(cyc);
    n_chk++; if (result !== 32'h1) $display("FAIL slt_neg got=%h want=1", result); else n_pass++;
    retire();
    issue(ALU_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_valid(cyc);
    n_chk++; if (result !== 32'h0) $display("FAIL slt_overflow got=%h want=0", result); else n_pass++;
    n_chk++; if (zero !== 1'b1) $display("FAIL slt_zero got=%b want=1", zero); else n_pass++;
    retire();
  endtask

  task automatic test_multu();
    int cyc;
    logic ready_seen;
    ready_seen = 1'b0;
    issue(ALU_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      if (in_ready !== 1'b0) ready_seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    n_chk++; if (cyc !== 33) $display("FAIL multu_latency got=%0d want=33", cyc); else n_pass++;
    n_chk++; if (ready_seen !== 1'b0) $display("FAIL multu_in_ready_busy got=1 want=0"); else n_pass++;
    n_chk++; if (hi !== 32'h1) $display("FAIL multu_hi got=%h want=1", hi); else n_pass++;
    n_chk++; if ({lo, result} !== {32'hFFFF_FFFE, 32'hFFFF_FFFE}) $display("FAIL multu_lo got=%h/%h want=fffffffe", lo, result); else n_pass++;
    m_hi = 32'h1; m_lo = 32'hFFFF_FFFE;
    retire();
  endtask

  task automatic test_divu();
    int cyc;
    issue(ALU_DIVU, 32'd100, 32'd7, 1'b0);
    wait_valid(cyc);
    n_chk++; if (cyc !== 33) $display("FAIL divu_latency got=%0d want=33", cyc); else n_pass++;
    n_chk++; if ({lo, hi} !== {32'd14, 32'd2}) $display("FAIL divu_100_7 got=%0d/%0d want=14/2", lo, hi); else n_pass++;
    retire();
    issue(ALU_DIVU, 32'd5, 32'd0, 1'b0);
    wait_valid(cyc);
    n_chk++; if ({lo, hi} !== {32'hFFFF_FFFF, 32'd5}) $display("FAIL divu_by_zero got=%h/%h want=ffffffff/5", lo, hi); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL divu_by_zero_err got=%b want=0", err); else n_pass++;
    m_hi = 32'd5; m_lo = 32'hFFFF_FFFF;
    retire();
  endtask

  task automatic test_reset_abort();
    int cyc;
    logic late_valid;
    issue(ALU_MULTU, $urandom, $urandom | 32'h1, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid got=%b want=0", out_valid); else n_pass++;
    n_chk++; if ({hi, lo, result} !== {3*W{1'b0}}) $display("FAIL abort_data got=%h/%h/%h want=0", hi, lo, result); else n_pass++;
    n_chk++; if (zero !== 1'b1) $display("FAIL abort_zero got=%b want=1", zero); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got=%b want=1", in_ready); else n_pass++;
    m_hi = '0; m_lo = '0;
    late_valid = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) late_valid = 1'b1; end
    n_chk++; if (late_valid !== 1'b0) $display("FAIL abort_result_lost got=1 want=0"); else n_pass++;
    issue(6'd0, $urandom, $urandom, 1'b1);
    wait_valid(cyc);
    n_chk++; if ({err, result} !== {1'b1, 32'h0}) $display("FAIL unsupported got=%b/%h want=1/0", err, result); else n_pass++;
    n_chk++; if ({hi, lo} !== {m_hi, m_lo}) $display("FAIL unsupported_hilo got=%h/%h want=%h/%h", hi, lo, m_hi, m_lo); else n_pass++;
    retire();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [W-1:0] x, y;
    exp_t e;
    x = $urandom; y = $urandom;
    e = model(ALU_OR, x, y, 1'b0, m_hi, m_lo);
    issue(ALU_OR, x, y, 1'b0);
    wait_valid(cyc);
    repeat (5) begin
      n_chk++;
      if ({out_valid, in_ready, result, carry, err} !== {1'b1, 1'b0, e.res, e.carry, e.err})
        $display("FAIL hold_stable got=%b%b %h want=10 %h", out_valid, in_ready, result, e.res);
      else n_pass++;
      @(posedge clk); #1;
    end
    retire();
    n_chk++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL done_exit got=%b want=01", {out_valid, in_ready}); else n_pass++;
    issue(ALU_AND, 32'd12, 32'd10, 1'b0);
    wait_valid(cyc);
    n_chk++; if (result !== 32'd8) $display("FAIL back_to_back_and got=%0d want=8", result); else n_pass++;
    retire();
  endtask

  task automatic test_random();
    logic [5:0] ops [11];
    logic [W-1:0] edges [4];
    logic [W-1:0] x, y;
    logic [5:0] c;
    logic ci;
    int cyc;
    exp_t e;
    ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MULTU, ALU_DIVU, 6'd0, 6'd33, 6'd63, ALU_SUB};
    edges = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 60; i++) begin
      c = ops[$urandom_range(0, 10)];
      x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 5) == 0) y = x;
      ci = 1'($urandom_range(0, 1));
      e = model(c, x, y, ci, m_hi, m_lo);
      n_chk++; if (in_ready !== 1'b1) $display("FAIL rnd_in_ready op=%0d got=%b want=1", c, in_ready); else n_pass++;
      issue(c, x, y, ci);
      wait_valid(cyc);
      n_chk++; if (cyc !== int'(e.lat)) $display("FAIL rnd_latency op=%0d got=%0d want=%0d", c, cyc, e.lat); else n_pass++;
      n_chk++;
      if ({result, carry, err, zero} !== {e.res, e.carry, e.err, e.res == '0})
        $display("FAIL rnd_result op=%0d a=%h b=%h cin=%b got=%h c%b e%b z%b want=%h c%b e%b", c, x, y, ci,
                 result, carry, err, zero, e.res, e.carry, e.err);
      else n_pass++;
      n_chk++;
      if ({hi, lo} !== {e.hi, e.lo})
        $display("FAIL rnd_hilo op=%0d a=%h b=%h got=%h/%h want=%h/%h", c, x, y, hi, lo, e.hi, e.lo);
      else n_pass++;
      m_hi = e.hi; m_lo = e.lo;
      retire();
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_slt();
    test_multu();
    test_divu();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
